// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: parses {count16, LE words, xor checksum}, writes
// each assembled word to instruction memory and releases core reset on a good frame.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        xfer;
    logic [15:0] count_full;
    logic [15:0] words_next;

    // Byte acceptance depends only on the parsing state and reset.
    always_comb begin
        in_ready = !rst && (state_q inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK});
    end

    assign xfer       = in_valid && in_ready;
    assign count_full = {in_data, count_q[7:0]};
    assign words_next = words_loaded_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        idx_d          = idx_q;
        word_d         = word_q;
        csum_d         = csum_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_rst_d     = core_rst_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;

        unique case (state_q)
            S_CNT_LO: begin
                if (xfer) begin
                    count_d = {8'd0, in_data};
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    count_d = count_full;
                    if (count_full > 16'(MAX_WORDS)) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else if (count_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = {in_data, word_q[23:8]};
                    csum_d = csum_q ^ in_data;
                    idx_d  = idx_q + 2'd1;
                    // Fourth byte completes a word: strobe it out next cycle.
                    if (idx_q == 2'd3) begin
                        imem_we_d      = 1'b1;
                        imem_wdata_d   = {in_data, word_q};
                        imem_addr_d    = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
                        words_loaded_d = words_next;
                        if (words_next == count_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d        = S_CNT_LO;
                    core_rst_d     = 1'b1;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = 16'd0;
                    csum_d         = 8'd0;
                    idx_d          = 2'd0;
                    count_d        = 16'd0;
                    imem_addr_d    = BASE_ADDR;
                end
            end
            default: state_d = S_CNT_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_CNT_LO;
            count_q        <= 16'd0;
            idx_q          <= 2'd0;
            word_q         <= 24'd0;
            csum_q         <= 8'd0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= 32'd0;
            core_rst_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_rst_q     <= core_rst_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table vectors, hand sequences and random frames
// checked against a frame-level reference model.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];
    int          m_consumed;
    bit          m_done;
    bit          m_err;
    int          m_wl;

    // Capture every write strobe as {addr, data}.
    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret the byte stream as a whole frame.
    function automatic void model();
        int          cnt;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_wl   = 0;
        cnt = int'({stream[1], stream[0]});
        m_consumed = 2;
        if (cnt > 256) begin
            m_err = 1'b1;
            return;
        end
        x = 8'd0;
        for (int k = 0; k < cnt; k++) begin
            w = {stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            exp_q.push_back({BASE + 32'(4*k), w});
        end
        m_wl = cnt;
        m_consumed = 2 + 4*cnt + 1;
        if (stream[m_consumed-1] == x) m_done = 1'b1;
        else m_err = 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_reload,
                             output bit ok);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            reload   = rnd_reload && ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        reload   = rnd_reload && ($urandom_range(0, 3) == 0);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;
    endtask

    function automatic int gap_for(input int mode, input int i);
        if (mode == 0) return 0;
        if (mode == 1) return (i % 2 == 1) ? 1 : int'($urandom_range(0, 5));
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
    endfunction

    task automatic run_stream(input string tag, input int mode, input bit rnd_reload);
        bit ok;
        model();
        for (int i = 0; i < m_consumed; i++) begin
            send_byte(stream[i], gap_for(mode, i), rnd_reload, ok);
            chk({tag, " accept"}, 32'(ok), 32'd1);
        end
        end_stream();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " waddr"}, got_q[i][63:32], exp_q[i][63:32]);
            chk({tag, " wdata"}, got_q[i][31:0], exp_q[i][31:0]);
        end
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " error"}, 32'(error), 32'(m_err));
        chk({tag, " core_rst"}, 32'(core_rst), 32'(!m_done));
        chk({tag, " words_loaded"}, 32'(words_loaded), 32'(m_wl));
        chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        reload = 1'b0;
        @(negedge clk);
        chk({tag, " rst in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " rst imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, " rst imem_addr"}, imem_addr, BASE);
        chk({tag, " rst core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, " rst done"}, 32'(done), 32'd0);
        chk({tag, " rst error"}, 32'(error), 32'd0);
        chk({tag, " rst words_loaded"}, 32'(words_loaded), 32'd0);
        rst = 1'b0;
        #1;
        chk({tag, " post-rst in_ready"}, 32'(in_ready), 32'd1);
        got_q.delete();
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk({tag, " reload core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, " reload done"}, 32'(done), 32'd0);
        chk({tag, " reload error"}, 32'(error), 32'd0);
        chk({tag, " reload words_loaded"}, 32'(words_loaded), 32'd0);
        chk({tag, " reload imem_addr"}, imem_addr, BASE);
        chk({tag, " reload in_ready"}, 32'(in_ready), 32'd1);
        got_q.delete();
    endtask

    typedef struct {
        int           len;
        logic [127:0] s;      // bytes MSB-first: byte 0 is the leftmost
        int           gap_mode;
        bit           e_done;
        bit           e_err;
        int           e_wl;
        int           e_nwr;
        logic [31:0]  e_w0;
        logic [31:0]  e_w1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit         ok;
        logic [15:0] cnt;
        logic [7:0]  x;
        logic [7:0]  b;

        vecs[0] = '{11, 128'h02_00_93_00_50_00_13_81_10_00_41, 0, 1'b1, 1'b0, 2, 2,
                    32'h00500093, 32'h00108113};
        vecs[1] = '{11, 128'h02_00_93_00_50_00_13_81_10_00_40, 0, 1'b0, 1'b1, 2, 2,
                    32'h00500093, 32'h00108113};
        vecs[2] = '{3, 128'h00_00_00, 0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0};
        vecs[3] = '{11, 128'h02_00_93_00_50_00_13_81_10_00_41, 1, 1'b1, 1'b0, 2, 2,
                    32'h00500093, 32'h00108113};
        vecs[4] = '{2, 128'h01_01, 0, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0};
        vecs[5] = '{3, 128'h00_00_05, 2, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0};

        for (int v = 0; v < 6; v++) begin
            do_reset($sformatf("vec%0d", v));
            stream.delete();
            for (int j = 0; j < vecs[v].len; j++)
                stream.push_back(vecs[v].s[8*(vecs[v].len-1-j) +: 8]);
            run_stream($sformatf("vec%0d", v), vecs[v].gap_mode, 1'b0);
            check_model($sformatf("vec%0d model", v));
            chk($sformatf("vec%0d tbl done", v), 32'(done), 32'(vecs[v].e_done));
            chk($sformatf("vec%0d tbl error", v), 32'(error), 32'(vecs[v].e_err));
            chk($sformatf("vec%0d tbl core_rst", v), 32'(core_rst), 32'(!vecs[v].e_done));
            chk($sformatf("vec%0d tbl words", v), 32'(words_loaded), 32'(vecs[v].e_wl));
            chk($sformatf("vec%0d tbl nwr", v), 32'(got_q.size()), 32'(vecs[v].e_nwr));
            if (vecs[v].e_nwr >= 2 && got_q.size() >= 2) begin
                chk($sformatf("vec%0d tbl w0 addr", v), got_q[0][63:32], BASE);
                chk($sformatf("vec%0d tbl w0 data", v), got_q[0][31:0], vecs[v].e_w0);
                chk($sformatf("vec%0d tbl w1 addr", v), got_q[1][63:32], BASE + 32'd4);
                chk($sformatf("vec%0d tbl w1 data", v), got_q[1][31:0], vecs[v].e_w1);
            end
        end

        // Oversize count: error right after the high count byte, nothing more taken.
        do_reset("over");
        send_byte(8'h01, 0, 1'b0, ok);
        send_byte(8'h01, 0, 1'b0, ok);
        #1;
        chk("over error edge", 32'(error), 32'd1);
        chk("over in_ready", 32'(in_ready), 32'd0);
        send_byte(8'h93, 0, 1'b0, ok);
        chk("over byte3 refused", 32'(ok), 32'd0);
        end_stream();
        chk("over no writes", 32'(got_q.size()), 32'd0);
        chk("over core_rst", 32'(core_rst), 32'd1);

        // Reset mid-frame, then resend the whole frame.
        do_reset("midrst");
        stream.delete();
        for (int j = 0; j < 11; j++) stream.push_back(vecs[0].s[8*(10-j) +: 8]);
        for (int j = 0; j < 5; j++) send_byte(stream[j], 0, 1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no write", 32'(got_q.size()), 32'd0);
        chk("midrst words", 32'(words_loaded), 32'd0);
        chk("midrst core_rst", 32'(core_rst), 32'd1);
        run_stream("midrst resend", 0, 1'b0);
        check_model("midrst resend");
        do_reload("midrst");

        // Largest legal frame.
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        x = 8'd0;
        for (int j = 0; j < 1024; j++) begin
            b = 8'($urandom);
            x = x ^ b;
            stream.push_back(b);
        end
        stream.push_back(x);
        run_stream("max", 0, 1'b0);
        check_model("max");
        do_reload("max");

        // Random frames with gaps and stray reload pulses.
        for (int it = 0; it < 40; it++) begin
            stream.delete();
            if ($urandom_range(0, 7) == 0) cnt = 16'($urandom_range(257, 65535));
            else cnt = 16'($urandom_range(0, 6));
            stream.push_back(cnt[7:0]);
            stream.push_back(cnt[15:8]);
            if (cnt <= 16'd256) begin
                x = 8'd0;
                for (int j = 0; j < 4*int'(cnt); j++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    stream.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) stream.push_back(x ^ 8'($urandom_range(1, 255)));
                else stream.push_back(x);
            end
            run_stream($sformatf("rnd%0d", it), 2, 1'b1);
            check_model($sformatf("rnd%0d", it));
            do_reload($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
